ea_astat: RTL and testbench

- ALU status register and status stack. Receives the flag-update strobes and flag values produced by the ALU, MAC and shifter, and holds ASTAT.
- Returns ASTAT to the ALU decode (AQ/AC feedback) and to the DMD bus.
- Provides a push/pop status stack for interrupt and CALL context save.
- Sits in the EU next to the ALU, closing the flag loop the ALU's decoder opens.

---
 rtl/ea_astat.sv | 142 ++++++++++++++
 tb/tb_ea_astat.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ea_astat.sv
// ea_astat: ALU status register (ASTAT) with a push/pop status stack.
// ASTAT collects the flags from the ALU, MAC and shifter. It feeds AQ and AC
// back to the ALU decoder and drives the DMD bus on register-move reads.
// The saturating status stack saves and restores ASTAT across interrupts and calls.
module ea_astat #(
   parameter int DEPTH = 4,
   parameter int PW    = 3
) (
   input  logic        DSPCLK,
   input  logic        T_RST,
   input  logic        GO_C,
   input  logic        updateALU,
   input  logic        ABS,
   input  logic        updateDIV,
   input  logic        AZin,
   input  logic        ANin,
   input  logic        AVin,
   input  logic        ACin,
   input  logic        ASin,
   input  logic        AQin,
   input  logic        updateMV,
   input  logic        MVin,
   input  logic        updateSS,
   input  logic        SSin,
   input  logic        MTASTAT_E,
   input  logic [15:0] R_in_E,
   input  logic        MFASTAT_E,
   input  logic        PUSH_STS,
   input  logic        POP_STS,
   input  logic        CLR_OVF,
   output logic [7:0]  ASTAT,
   output logic [15:0] DMDastat,
   output logic        STS_EMPTY,
   output logic        STS_FULL,
   output logic        STS_OVF
);

   localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

   logic [7:0]         astat_q, astat_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic               ovf_q, ovf_d;
   logic [DEPTH*8-1:0] stack_flat;
   logic [PW-1:0]      pop_idx;
   logic [7:0]         pop_val;
   logic               empty, full;
   logic               do_push, do_pop, push_ok, push_ovf;

   // The upper byte of the write data has no destination in ASTAT.
   logic unused_r_hi;
   assign unused_r_hi = ^R_in_E[15:8];

   assign empty   = (ptr_q == '0);
   assign full    = (ptr_q == PTR_FULL);
   // A simultaneous push and pop cancel each other; a pop from empty does nothing.
   assign do_push  = PUSH_STS & ~POP_STS;
   assign do_pop   = POP_STS & ~PUSH_STS & ~empty;
   assign push_ok  = do_push & ~full;
   assign push_ovf = do_push & full;
   assign pop_idx  = ptr_q - 1'b1;

   // Stack entries are written only by a successful push. The value written is
   // the ASTAT held at the start of the cycle, not this cycle's update.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_stk
         logic [7:0] entry_q;
         // Write this entry when the pointer selects it on a successful push.
         always_ff @(posedge DSPCLK) begin
            if (!T_RST && GO_C && push_ok && (ptr_q == PW'(gi))) begin
               entry_q <= astat_q;
            end
         end
         assign stack_flat[gi*8 +: 8] = entry_q;
      end
   endgenerate

   // Select the top-of-stack entry for a pop.
   always_comb begin
      pop_val = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         if (pop_idx == PW'(i)) begin
            pop_val = stack_flat[i*8 +: 8];
         end
      end
   end

   // Next state. A register move beats a pop, and a pop beats the flag strobes.
   // The flag strobes update independent bits.
   always_comb begin
      astat_d = astat_q;
      ptr_d   = ptr_q;
      ovf_d   = ovf_q;
      if (GO_C) begin
         if (MTASTAT_E) begin
            astat_d = R_in_E[7:0];
         end else if (do_pop) begin
            astat_d = pop_val;
         end else begin
            if (updateALU) begin
               astat_d[3:0] = {ACin, AVin, ANin, AZin};
               if (ABS) begin
                  astat_d[4] = ASin;
               end
            end
            if (updateDIV) astat_d[5] = AQin;
            if (updateMV)  astat_d[6] = MVin;
            if (updateSS)  astat_d[7] = SSin;
         end
         if (push_ok) begin
            ptr_d = ptr_q + 1'b1;
         end else if (do_pop) begin
            ptr_d = ptr_q - 1'b1;
         end
         // A new overflow wins over a clear in the same cycle.
         if (push_ovf) begin
            ovf_d = 1'b1;
         end else if (CLR_OVF) begin
            ovf_d = 1'b0;
         end
      end
   end

   // State registers. Reset takes effect regardless of GO_C.
   always_ff @(posedge DSPCLK) begin
      if (T_RST) begin
         astat_q <= 8'h00;
         ptr_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         astat_q <= astat_d;
         ptr_q   <= ptr_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ASTAT     = astat_q;
   assign DMDastat  = MFASTAT_E ? {8'h00, astat_q} : 16'h0000;
   assign STS_EMPTY = empty;
   assign STS_FULL  = full;
   assign STS_OVF   = ovf_q;

endmodule

// File: tb/tb_ea_astat.sv
// Testbench for ea_astat. A table of directed vectors is applied one per clock.
// Each vector supplies the inputs, the expected DMD value before the edge, and the
// expected ASTAT and stack flags after the edge. Hand-written sequences follow the table.
module tb_ea_astat;

   logic        DSPCLK = 1'b0;
   logic        T_RST, GO_C, updateALU, ABS, updateDIV;
   logic        AZin, ANin, AVin, ACin, ASin, AQin;
   logic        updateMV, MVin, updateSS, SSin;
   logic        MTASTAT_E, MFASTAT_E, PUSH_STS, POP_STS, CLR_OVF;
   logic [15:0] R_in_E;
   logic [7:0]  ASTAT;
   logic [15:0] DMDastat;
   logic        STS_EMPTY, STS_FULL, STS_OVF;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 DSPCLK = ~DSPCLK;

   ea_astat #(.DEPTH(4), .PW(3)) dut (
      .DSPCLK(DSPCLK), .T_RST(T_RST), .GO_C(GO_C),
      .updateALU(updateALU), .ABS(ABS), .updateDIV(updateDIV),
      .AZin(AZin), .ANin(ANin), .AVin(AVin), .ACin(ACin), .ASin(ASin), .AQin(AQin),
      .updateMV(updateMV), .MVin(MVin), .updateSS(updateSS), .SSin(SSin),
      .MTASTAT_E(MTASTAT_E), .R_in_E(R_in_E), .MFASTAT_E(MFASTAT_E),
      .PUSH_STS(PUSH_STS), .POP_STS(POP_STS), .CLR_OVF(CLR_OVF),
      .ASTAT(ASTAT), .DMDastat(DMDastat),
      .STS_EMPTY(STS_EMPTY), .STS_FULL(STS_FULL), .STS_OVF(STS_OVF)
   );

   // stb = {updateSS, updateMV, updateDIV, ABS, updateALU}
   // fin = {SSin, MVin, AQin, ASin, ACin, AVin, ANin, AZin}
   typedef struct {
      logic        rst;
      logic        go;
      logic [4:0]  stb;
      logic [7:0]  fin;
      logic        mt;
      logic [15:0] r;
      logic        mf;
      logic        push;
      logic        pop;
      logic        clr;
      logic [15:0] e_dmd;
      logic [7:0]  e_astat;
      logic        e_empty;
      logic        e_full;
      logic        e_ovf;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic go, input logic [4:0] stb,
                      input logic [7:0] fin, input logic mt, input logic [15:0] r,
                      input logic mf, input logic push, input logic pop, input logic clr,
                      input logic [15:0] e_dmd, input logic [7:0] e_astat,
                      input logic e_empty, input logic e_full, input logic e_ovf);
      vec_t v;
      v.rst = rst; v.go = go; v.stb = stb; v.fin = fin; v.mt = mt; v.r = r;
      v.mf = mf; v.push = push; v.pop = pop; v.clr = clr;
      v.e_dmd = e_dmd; v.e_astat = e_astat;
      v.e_empty = e_empty; v.e_full = e_full; v.e_ovf = e_ovf;
      vq.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      T_RST = v.rst; GO_C = v.go;
      {updateSS, updateMV, updateDIV, ABS, updateALU} = v.stb;
      {SSin, MVin, AQin, ASin, ACin, AVin, ANin, AZin} = v.fin;
      MTASTAT_E = v.mt; R_in_E = v.r; MFASTAT_E = v.mf;
      PUSH_STS = v.push; POP_STS = v.pop; CLR_OVF = v.clr;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Apply one vector: check the bus before the edge, then the state after it.
   task automatic run_vec(input int idx, input vec_t v);
      @(negedge DSPCLK);
      drive(v);
      #1;
      chk($sformatf("v%0d dmd", idx), DMDastat, v.e_dmd);
      @(posedge DSPCLK);
      #1;
      chk($sformatf("v%0d astat", idx), {8'h00, ASTAT}, {8'h00, v.e_astat});
      chk($sformatf("v%0d empty", idx), {15'h0, STS_EMPTY}, {15'h0, v.e_empty});
      chk($sformatf("v%0d full", idx), {15'h0, STS_FULL}, {15'h0, v.e_full});
      chk($sformatf("v%0d ovf", idx), {15'h0, STS_OVF}, {15'h0, v.e_ovf});
      $display("vec %0d: astat=%h dmd=%h empty=%b full=%b ovf=%b",
               idx, ASTAT, DMDastat, STS_EMPTY, STS_FULL, STS_OVF);
   endtask

   initial begin
      vec_t idle;
      idle = '{rst:1'b0, go:1'b1, stb:5'b0, fin:8'h00, mt:1'b0, r:16'h0, mf:1'b0,
               push:1'b0, pop:1'b0, clr:1'b0, e_dmd:16'h0, e_astat:8'h00,
               e_empty:1'b1, e_full:1'b0, e_ovf:1'b0};
      drive(idle);

      //   rst go  stb       fin    mt r        mf pu po cl  e_dmd    e_astat E  F  O
      add(1, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0); // reset
      add(0, 1, 5'b00001, 8'h1D, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h0D, 1, 0, 0); // ALU, ABS=0
      add(0, 1, 5'b00001, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0);
      add(0, 1, 5'b00101, 8'h21, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h21, 1, 0, 0); // DIV+ALU
      add(0, 1, 5'b00101, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0);
      add(0, 0, 5'b00101, 8'h21, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0); // GO_C=0
      add(0, 1, 5'b00011, 8'h10, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h10, 1, 0, 0); // ABS -> AS
      add(0, 1, 5'b11000, 8'hC0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'hD0, 1, 0, 0); // MV, SS
      add(0, 1, 5'b00001, 8'h00, 1, 16'hFFA5, 0, 0, 0, 0, 16'h0000, 8'hA5, 1, 0, 0); // MT beats ALU
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 16'h00A5, 8'hA5, 1, 0, 0); // MF read
      add(0, 1, 5'b00000, 8'h00, 1, 16'h0001, 1, 0, 0, 0, 16'h00A5, 8'h01, 1, 0, 0); // bus = old
      add(0, 1, 5'b00000, 8'h00, 1, 16'h0002, 0, 1, 0, 0, 16'h0000, 8'h02, 0, 0, 0); // push 01
      add(0, 1, 5'b00000, 8'h00, 1, 16'h0003, 0, 1, 0, 0, 16'h0000, 8'h03, 0, 0, 0); // push 02
      add(0, 1, 5'b00000, 8'h00, 1, 16'h0004, 0, 1, 0, 0, 16'h0000, 8'h04, 0, 0, 0); // push 03
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h04, 0, 1, 0); // push 04
      add(0, 1, 5'b00000, 8'h00, 1, 16'h0055, 0, 1, 0, 0, 16'h0000, 8'h55, 0, 1, 1); // overflow
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 8'h04, 0, 0, 1); // pop
      add(0, 1, 5'b00001, 8'h01, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 8'h03, 0, 0, 1); // pop+ALU
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 8'h02, 0, 0, 1);
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 8'h01, 1, 0, 1);
      add(0, 1, 5'b00001, 8'h0F, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 8'h0F, 1, 0, 1); // pop empty
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 8'h0F, 1, 0, 0); // clear ovf
      add(0, 1, 5'b00000, 8'h00, 1, 16'h0033, 0, 0, 0, 0, 16'h0000, 8'h33, 1, 0, 0);
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h33, 0, 0, 0); // top=33
      add(0, 1, 5'b00000, 8'h00, 1, 16'h0010, 0, 0, 0, 0, 16'h0000, 8'h10, 0, 0, 0);
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 1, 0, 16'h0000, 8'h10, 0, 0, 0); // push+pop
      add(0, 1, 5'b00001, 8'h01, 0, 16'h0000, 0, 1, 1, 0, 16'h0000, 8'h11, 0, 0, 0); // +ALU applies
      add(0, 1, 5'b00000, 8'h00, 1, 16'h0010, 0, 0, 0, 0, 16'h0000, 8'h10, 0, 0, 0);
      add(0, 1, 5'b00001, 8'h01, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 8'h33, 1, 0, 0); // pop beats ALU
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h33, 0, 0, 0);
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h33, 0, 0, 0);
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h33, 0, 0, 0);
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h33, 0, 1, 0); // full
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 0, 1, 16'h0000, 8'h33, 0, 1, 1); // set > clr
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 8'h33, 0, 0, 1); // ptr 3
      add(0, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 8'h33, 0, 0, 1); // ptr 2
      add(1, 1, 5'b00000, 8'h00, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h00, 1, 0, 0); // rst+push
      add(0, 1, 5'b00000, 8'h00, 1, 16'h00AA, 0, 0, 0, 0, 16'h0000, 8'hAA, 1, 0, 0);
      add(1, 0, 5'b00000, 8'h00, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0); // rst, GO_C=0

      for (int i = 0; i < vq.size(); i++) begin
         run_vec(i, vq[i]);
      end

      // Stalled push and clear are dropped, not queued for the next advance.
      @(negedge DSPCLK);
      drive(idle);
      GO_C = 1'b0; PUSH_STS = 1'b1; MTASTAT_E = 1'b1; R_in_E = 16'h005A;
      @(posedge DSPCLK); #1;
      chk("stall push empty", {15'h0, STS_EMPTY}, 16'h0001);
      chk("stall mt astat", {8'h00, ASTAT}, 16'h0000);
      @(negedge DSPCLK);
      drive(idle);
      @(posedge DSPCLK); #1;
      chk("resume empty", {15'h0, STS_EMPTY}, 16'h0001);
      chk("resume astat", {8'h00, ASTAT}, 16'h0000);
      $display("seq stall: astat=%h empty=%b", ASTAT, STS_EMPTY);

      // Pushed value is the pre-update ASTAT when a flag strobe coincides.
      @(negedge DSPCLK);
      drive(idle);
      MTASTAT_E = 1'b1; R_in_E = 16'h0066;
      @(negedge DSPCLK);
      drive(idle);
      PUSH_STS = 1'b1; updateALU = 1'b1; {ACin, AVin, ANin, AZin} = 4'b1111;
      @(posedge DSPCLK); #1;
      chk("push+alu astat", {8'h00, ASTAT}, 16'h006F);
      @(negedge DSPCLK);
      drive(idle);
      POP_STS = 1'b1;
      @(posedge DSPCLK); #1;
      chk("pop old value", {8'h00, ASTAT}, 16'h0066);
      chk("pop empty", {15'h0, STS_EMPTY}, 16'h0001);
      $display("seq push-old: astat=%h empty=%b", ASTAT, STS_EMPTY);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
